// File: rtl/min_max_finder_param.sv
// Sequential min/max search over an internal register array, one element per cycle.
// Optional index tracking: define MMF_INDEX_EN to report MaxIdx/MinIdx, otherwise they read 0.
//
// state | meaning
// INI   | idle; array writable; waits for Start
// LOAD  | seed Max/Min from element 0
// CMP   | compare element I against running Max/Min
// DONE  | results held until Ack
module min_max_finder_param #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Ack,
  input  logic             Signed,
  input  logic [AW:0]      Len,
  input  logic             WrEn,
  input  logic [AW-1:0]    WrAddr,
  input  logic [WIDTH-1:0] WrData,
  output logic [WIDTH-1:0] Max,
  output logic [WIDTH-1:0] Min,
  output logic [AW-1:0]    MaxIdx,
  output logic [AW-1:0]    MinIdx,
  output logic             Qi,
  output logic             Ql,
  output logic             Qc,
  output logic             Qd
);

  typedef enum logic [3:0] {
    ST_INI  = 4'b0001,
    ST_LOAD = 4'b0010,
    ST_CMP  = 4'b0100,
    ST_DONE = 4'b1000
  } state_t;

  localparam logic [AW:0] N_ONE = (AW+1)'(1);
  localparam logic [AW:0] N_MAX = (AW+1)'(DEPTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    idx;
  logic [AW:0]      n_lat, n_clamp;
  logic             sgn_lat;
  logic [WIDTH-1:0] elem;
  logic             gt, lt, last;

  assign Qi = state[0];
  assign Ql = state[1];
  assign Qc = state[2];
  assign Qd = state[3];

  always_comb begin
    n_clamp = Len;
    if (Len == '0)
      n_clamp = N_ONE;
    else if (Len > N_MAX)
      n_clamp = N_MAX;
  end

  assign elem = mem[idx];
  assign gt   = sgn_lat ? ($signed(elem) > $signed(Max)) : (elem > Max);
  assign lt   = sgn_lat ? ($signed(elem) < $signed(Min)) : (elem < Min);
  assign last = ({1'b0, idx} == (n_lat - N_ONE));

  // Array is deliberately outside reset so contents survive it.
  always_ff @(posedge Clk) begin
    if (WrEn && state == ST_INI)
      mem[WrAddr] <= WrData;
  end

  always_ff @(posedge Clk) begin
    if (Reset)
      state <= ST_INI;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_INI:  if (Start) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = (n_lat == N_ONE) ? ST_DONE : ST_CMP;
      ST_CMP:  if (last) state_nxt = ST_DONE;
      ST_DONE: if (Ack) state_nxt = ST_INI;
      default: state_nxt = ST_INI;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Max     <= '0;
      Min     <= '0;
      idx     <= '0;
      n_lat   <= N_ONE;
      sgn_lat <= 1'b0;
    end else begin
      case (state)
        ST_INI: if (Start) begin
          sgn_lat <= Signed;
          n_lat   <= n_clamp;
          idx     <= '0;
        end
        ST_LOAD: begin
          Max <= mem[0];
          Min <= mem[0];
          // single-element search keeps I at 0 so it never passes N-1
          idx <= (n_lat == N_ONE) ? '0 : AW'(1);
        end
        ST_CMP: begin
          if (gt) Max <= elem;
          if (lt) Min <= elem;
          if (!last) idx <= idx + AW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef MMF_INDEX_EN
  logic [AW-1:0] max_idx_r, min_idx_r;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      max_idx_r <= '0;
      min_idx_r <= '0;
    end else if (state == ST_LOAD) begin
      max_idx_r <= '0;
      min_idx_r <= '0;
    end else if (state == ST_CMP) begin
      if (gt) max_idx_r <= idx;
      if (lt) min_idx_r <= idx;
    end
  end

  assign MaxIdx = max_idx_r;
  assign MinIdx = min_idx_r;
`else
  assign MaxIdx = '0;
  assign MinIdx = '0;
`endif

endmodule

// File: tb/tb_min_max_finder_param.sv
// Bench for min_max_finder_param: directed corner cases plus randomized searches
// checked against an array-scan reference model.
module tb_min_max_finder_param;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef MMF_INDEX_EN
  localparam bit IDX_EN = 1'b1;
`else
  localparam bit IDX_EN = 1'b0;
`endif

  logic             Clk, Reset, Start, Ack, Signed, WrEn;
  logic [AW:0]      Len;
  logic [AW-1:0]    WrAddr;
  logic [WIDTH-1:0] WrData;
  logic [WIDTH-1:0] Max, Min;
  logic [AW-1:0]    MaxIdx, MinIdx;
  logic             Qi, Ql, Qc, Qd;

  min_max_finder_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Signed(Signed),
    .Len(Len), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .Max(Max), .Min(Min), .MaxIdx(MaxIdx), .MinIdx(MinIdx),
    .Qi(Qi), .Ql(Ql), .Qc(Qc), .Qd(Qd)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] mdl [DEPTH];
  logic [WIDTH-1:0] exp_max, exp_min;
  int               exp_n, exp_maxi, exp_mini;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int val(input bit sgn, input logic [WIDTH-1:0] x);
    return sgn ? int'($signed(x)) : int'(x);
  endfunction

  // Reference: plain scan, strict compare so the first occurrence wins ties.
  task automatic model(input bit sgn, input int len);
    exp_n = (len == 0) ? 1 : (len > DEPTH) ? DEPTH : len;
    exp_maxi = 0;
    exp_mini = 0;
    for (int i = 1; i < exp_n; i++) begin
      if (val(sgn, mdl[i]) > val(sgn, mdl[exp_maxi])) exp_maxi = i;
      if (val(sgn, mdl[i]) < val(sgn, mdl[exp_mini])) exp_mini = i;
    end
    exp_max = mdl[exp_maxi];
    exp_min = mdl[exp_mini];
  endtask

  task automatic write_word(input int a, input logic [WIDTH-1:0] d);
    @(negedge Clk);
    WrEn = 1'b1; WrAddr = AW'(a); WrData = d;
    @(posedge Clk); #1;
    WrEn = 1'b0;
    mdl[a] = d;
  endtask

  task automatic check_results(input string tag);
    check_val({tag, "_max"}, 32'(Max), 32'(exp_max));
    check_val({tag, "_min"}, 32'(Min), 32'(exp_min));
    check_val({tag, "_maxidx"}, 32'(MaxIdx), IDX_EN ? 32'(exp_maxi) : 32'd0);
    check_val({tag, "_minidx"}, 32'(MinIdx), IDX_EN ? 32'(exp_mini) : 32'd0);
  endtask

  task automatic run_search(input bit sgn, input int len, input int hold,
                            input bit hold_start, input bit junk_wr);
    int edges;
    model(sgn, len);
    @(negedge Clk);
    Signed = sgn; Len = (AW+1)'(len); Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    check_val("load_state", 32'({Qi, Ql, Qc, Qd}), 32'b0100);
    if (junk_wr) begin
      WrEn = 1'b1; WrAddr = AW'($urandom); WrData = WIDTH'($urandom);
    end
    edges = 0;
    while (!Qd && edges < 64) begin
      @(posedge Clk); #1;
      edges++;
    end
    check_val("latency", 32'(edges), 32'(exp_n));
    check_results("done");
    for (int h = 0; h < hold; h++) begin
      Start = hold_start;
      @(posedge Clk); #1;
      check_val("hold_qd", 32'({Qi, Ql, Qc, Qd}), 32'b0001);
      check_results("hold");
    end
    Ack = 1'b1;
    @(posedge Clk); #1;
    Ack = 1'b0; Start = 1'b0; WrEn = 1'b0;
    check_val("ack_ini", 32'({Qi, Ql, Qc, Qd}), 32'b1000);
    check_results("ini");
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Ack = 1'b0; Signed = 1'b0; Len = '0;
    WrEn = 1'b0; WrAddr = '0; WrData = '0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    check_val("rst_state", 32'({Qi, Ql, Qc, Qd}), 32'b1000);
    check_val("rst_max", 32'(Max), 32'd0);
    check_val("rst_min", 32'(Min), 32'd0);

    // Ascending 0..15 unsigned full depth
    for (int i = 0; i < DEPTH; i++) write_word(i, WIDTH'(i));
    run_search(1'b0, 16, 0, 1'b0, 1'b0);

    // Signed vs unsigned interpretation of the same data
    write_word(0, 8'h7F); write_word(1, 8'h80); write_word(2, 8'h01); write_word(3, 8'hFF);
    run_search(1'b1, 4, 0, 1'b0, 1'b0);
    run_search(1'b0, 4, 0, 1'b0, 1'b0);

    // Ties report the lowest index; long DONE dwell with Start held
    write_word(0, 8'd5); write_word(1, 8'd9); write_word(2, 8'd9);
    write_word(3, 8'd2); write_word(4, 8'd2);
    run_search(1'b0, 5, 10, 1'b1, 1'b0);

    // Length clamping
    run_search(1'b0, 0, 0, 1'b0, 1'b0);
    run_search(1'b1, 31, 0, 1'b0, 1'b0);

    // Reset in mid-scan at I=6
    for (int i = 0; i < DEPTH; i++) write_word(i, WIDTH'($urandom));
    @(negedge Clk);
    Signed = 1'b0; Len = 5'd16; Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
    repeat (6) @(posedge Clk);
    #1;
    check_val("midscan_cmp", 32'({Qi, Ql, Qc, Qd}), 32'b0010);
    Reset = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;
    check_val("midrst_state", 32'({Qi, Ql, Qc, Qd}), 32'b1000);
    check_val("midrst_max", 32'(Max), 32'd0);
    check_val("midrst_min", 32'(Min), 32'd0);
    check_val("midrst_maxidx", 32'(MaxIdx), 32'd0);
    check_val("midrst_minidx", 32'(MinIdx), 32'd0);

    // Array survives reset; writes outside INI are ignored
    run_search(1'b0, 16, 3, 1'b0, 1'b1);
    run_search(1'b1, 16, 0, 1'b0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      int nw;
      nw = int'($urandom_range(0, 6));
      for (int w = 0; w < nw; w++)
        write_word(int'($urandom_range(0, DEPTH - 1)), WIDTH'($urandom));
      run_search(1'($urandom), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
